// File: rtl/instr_encoder.sv
// instr_encoder: packs a one-hot instruction class plus operand fields
// into a 32-bit MIPS word and streams it out with a running byte address.
module instr_encoder #(
  parameter int unsigned       ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              err,
  output logic [15:0]       word_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q, out_word_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_q, err_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic              sel_onehot;
  logic [10:0]       sel_oh;
  logic [31:0]       enc_word;
  logic              accept;
  logic              acc_ok;
  logic              acc_bad;
  logic              hs;
  logic [ADDR_W-1:0] word_addr;

  // Masked select keeps the unique decoder free of multi-hot matches.
  always_comb begin
    sel_onehot = (sel != '0) && ((sel & (sel - 11'd1)) == '0);
    sel_oh     = sel_onehot ? sel : '0;
  end

  always_comb begin
    enc_word = '0;
    unique case (1'b1)
      sel_oh[0]:  enc_word = {OP_R, rs, rt, rd, shamt, funct};
      sel_oh[1]:  enc_word = {OP_ADDI, rs, rt, imm};
      sel_oh[2]:  enc_word = {OP_ANDI, rs, rt, imm};
      sel_oh[3]:  enc_word = {OP_ORI, rs, rt, imm};
      sel_oh[4]:  enc_word = {OP_XORI, rs, rt, imm};
      sel_oh[5]:  enc_word = {OP_LW, rs, rt, imm};
      sel_oh[6]:  enc_word = {OP_SW, rs, rt, imm};
      sel_oh[7]:  enc_word = {OP_BEQ, rs, rt, imm};
      sel_oh[8]:  enc_word = {OP_LUI, 5'd0, rt, imm};
      sel_oh[9]:  enc_word = {OP_J, target};
      sel_oh[10]: enc_word = {OP_JAL, target};
      default:    enc_word = '0;
    endcase
  end

  always_comb begin
    in_ready  = !out_valid_q || out_ready;
    accept    = in_valid && in_ready;
    acc_ok    = accept && sel_onehot;
    acc_bad   = accept && !sel_onehot;
    hs        = out_valid_q && out_ready;
    word_addr = start ? BASE : next_addr_q;
  end

  always_comb begin
    next_addr_d = next_addr_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    if (start) begin
      next_addr_d = BASE;
    end
    if (acc_ok) begin
      next_addr_d = word_addr + STEP;
      out_word_d  = enc_word;
      out_addr_d  = word_addr;
      out_valid_d = 1'b1;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_d      = acc_bad;
    word_cnt_d = word_cnt_q;
    if (hs && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      next_addr_q <= BASE;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder for the single-cycle CPU toolchain path. It accepts one decoded instruction class (one-hot) plus operand fields over a valid/ready handshake, and packs them into a 32-bit MIPS machine word. It emits each word with an auto-incrementing byte address toward instruction-memory load logic. It is the inverse of the CPU's opcode-to-class decoding and uses the same 11-instruction subset.

## Interface

**Parameters**
- `ADDR_W`, default 32: width of the byte address counter.
- `BASE`, default 0: load address after reset or `start`.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: synchronous pulse; reloads the address counter to `BASE`.
- `in_valid`, in, 1: input fields are valid.
- `in_ready`, out, 1: block can accept the input this cycle.
- `sel`, in, 11: one-hot class select. Bit mapping:
  - [0] R_type, [1] addi, [2] andi, [3] ori, [4] xori, [5] lw
  - [6] sw, [7] beq, [8] lui, [9] j, [10] jal
- `rs`, `rt`, `rd`, `shamt`, in, 5 each: register and shift fields.
- `funct`, in, 6: R-type function field.
- `imm`, in, 16: I-type immediate.
- `target`, in, 26: J-type target.
- `out_valid`, out, 1: `out_word` / `out_addr` hold a valid word.
- `out_ready`, in, 1: downstream accepts the word.
- `out_addr`, out, ADDR_W: byte address of the word.
- `out_word`, out, 32: encoded instruction.
- `err`, out, 1: one-cycle pulse; an input with invalid `sel` was accepted.
- `word_cnt`, out, 16: count of words emitted (handshake completions); saturates at 0xFFFF.

## Operation

**Opcodes**
- R 000000, addi 001000, andi 001100, ori 001101, xori 001110, lw 100011
- sw 101011, beq 000100, lui 001111, j 000010, jal 000011

**Packing**
- R-type: {op, rs, rt, rd, shamt, funct}.
- addi/andi/ori/xori/lw/sw/beq: {op, rs, rt, imm}.
- lui: {op, 5'b0, rt, imm}; the `rs` input is ignored.
- j/jal: {op, target}.

**Datapath and control**
- Single output register stage. `in_ready = !out_valid || out_ready`.
- An accept is `in_valid && in_ready`.
- Accept with valid one-hot `sel`:
  - Load `out_word`, load `out_addr` = next address, set `out_valid`.
  - Next address += 4, modulo 2^ADDR_W (wraps silently).
- Accept with `sel` zero or multi-hot:
  - Input is consumed and dropped; `err` pulses next cycle.
  - Address does not advance.
  - `out_valid` clears if the prior word handshakes that same cycle; otherwise it stays unchanged.
- `out_valid && out_ready` completes the output handshake.
  - `word_cnt` increments, saturating.
  - `out_valid` clears unless a new valid word is accepted that same cycle.

**`start` rules**
- `start` sets the next address to `BASE`.
- If `start` coincides with a valid accept, that word takes address `BASE` and the next address becomes `BASE+4`.
- `start` does not discard a pending output word and does not clear `word_cnt`.

**Reset values**
- `out_valid`=0, `out_word`=0, `out_addr`=0, `err`=0, `word_cnt`=0, next address=`BASE`.
- Reset mid-handshake drops any pending word.

**Output stability**
- While `out_valid && !out_ready`: `out_word` and `out_addr` hold stable and `in_ready`=0.

## Timing

- Latency: accept in cycle N gives `out_valid` in cycle N+1.
- Throughput is one word per clock while `out_ready` stays high.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- `err` is registered and high for exactly one cycle per invalid accept. Back-to-back invalid accepts give consecutive high cycles.
- Deasserting `rst_n` clears state immediately, without waiting for a clock edge. The first accept is possible on the first rising edge after release.

## Test plan

- **Reset and single R-type:** reset, then R_type with rs=1, rt=2, rd=3, shamt=0, funct=0x20 → next cycle `out_word`=0x00221820, `out_addr`=0, `out_valid`=1.
- **Streaming, out_ready=1:**
  - Input sequence: addi rs=1 rt=2 imm=5; lw rs=29 rt=8 imm=0xFFFC; sw (same fields); jal target=0x10.
  - Expected words: 0x20220005@0, 0x8FA8FFFC@4, 0xAFA8FFFC@8, 0x0C000010@12.
  - `word_cnt`=4.
- **lui rs masking:** lui rs=7, rt=4, imm=0xABCD → 0x3C04ABCD.
- **Backpressure:**
  - Hold `out_ready`=0 for 3 cycles with a word pending → `in_ready`=0 and outputs stable.
  - Release → handshake completes and the next word is accepted the same cycle.
- **Invalid select:**
  - `sel`=0 or `sel`=0x003 → `err` pulses one cycle, no output, address unchanged.
  - The following valid word takes the un-advanced address.
- **start, wrap and async reset:**
  - With ADDR_W=4 and BASE=8, emit words → addresses 8, 12, 0.
  - `start` coincident with an accept → that word goes to address 8.
  - `rst_n` low while a word is pending → `out_valid` drops immediately.
